// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, player codes and board dimensions for game_turn_controller
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    WAIT_MOVE = 3'd2,
    VALIDATE  = 3'd3,
    INSERT    = 3'd4,
    CHECK     = 3'd5,
    GAME_OVER = 3'd6
  } state_t;

  localparam logic [1:0] PLAYER_NONE = 2'b00;
  localparam logic [1:0] PLAYER1     = 2'b01;
  localparam logic [1:0] PLAYER2     = 2'b10;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int MAX_MOVES = ROWS * COLS;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PLAYER1) ? PLAYER2 : PLAYER1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn cycle counter, expired is high on the last cycle of the turn
module turn_timer #(
  parameter int TURN_CYCLES = 500000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TURN_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = en && (count == LAST);

  // Expiry wraps to zero so the next player gets a full turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || expired) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/game_turn_controller.sv
// rtl/game_turn_controller.sv - turn sequencing FSM for a two-player column game; TURN_TIMER_EN adds a turn timeout
module game_turn_controller
  import game_pkg::*;
#(
  parameter int TURN_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       confirm,
  input  logic [2:0] col_in,
  input  logic       col_full,
  input  logic       check_done,
  input  logic       winner_found,
  output logic       board_rst_n,
  output logic       insert_en,
  output logic [2:0] col_sel,
  output logic [1:0] player_id,
  output logic       check_req,
  output logic       invalid_move,
  output logic       timeout,
  output logic [1:0] winner,
  output logic       draw,
  output logic [5:0] move_count,
  output logic [2:0] state
);

  state_t      state_q, state_d;
  logic        board_rst_n_q, insert_en_q, check_req_q, draw_q;
  logic [2:0]  col_sel_q;
  logic [1:0]  player_q, winner_q;
  logic [5:0]  move_count_q;
  logic        bad_move, turn_expired, board_full;

  assign bad_move   = col_full || (col_sel_q >= 3'(COLS));
  assign board_full = (move_count_q == 6'(MAX_MOVES));

`ifdef TURN_TIMER_EN
  logic expired;

  turn_timer #(
    .TURN_CYCLES(TURN_CYCLES)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != WAIT_MOVE),
    .en      (state_q == WAIT_MOVE),
    .expired (expired)
  );

  // A confirm landing on the expiry cycle wins over the timeout.
  assign turn_expired = (state_q == WAIT_MOVE) && expired && !confirm;
`else
  assign turn_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, GAME_OVER: if (start) state_d = CLEAR;
      CLEAR:           state_d = WAIT_MOVE;
      WAIT_MOVE:       if (confirm) state_d = VALIDATE;
      VALIDATE:        state_d = bad_move ? WAIT_MOVE : INSERT;
      INSERT:          state_d = CHECK;
      CHECK: begin
        if (check_done) begin
          state_d = (winner_found || board_full) ? GAME_OVER : WAIT_MOVE;
        end
      end
      default:         state_d = IDLE;
    endcase
  end

  // Strobes are registered from state_d so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      board_rst_n_q <= 1'b1;
      insert_en_q   <= 1'b0;
      check_req_q   <= 1'b0;
      col_sel_q     <= 3'd0;
      player_q      <= PLAYER1;
      winner_q      <= PLAYER_NONE;
      draw_q        <= 1'b0;
      move_count_q  <= 6'd0;
    end else begin
      state_q       <= state_d;
      board_rst_n_q <= (state_d != CLEAR);
      insert_en_q   <= (state_d == INSERT);
      check_req_q   <= (state_d == CHECK);
      case (state_q)
        CLEAR: begin
          move_count_q <= 6'd0;
          winner_q     <= PLAYER_NONE;
          draw_q       <= 1'b0;
          player_q     <= PLAYER1;
        end
        WAIT_MOVE: begin
          if (confirm) begin
            col_sel_q <= col_in;
          end else if (turn_expired) begin
            player_q <= other_player(player_q);
          end
        end
        INSERT: move_count_q <= move_count_q + 6'd1;
        CHECK: begin
          if (check_done) begin
            if (winner_found) begin
              winner_q <= player_q;
            end else if (board_full) begin
              draw_q <= 1'b1;
            end else begin
              player_q <= other_player(player_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign board_rst_n  = board_rst_n_q;
  assign insert_en    = insert_en_q;
  assign check_req    = check_req_q;
  assign col_sel      = col_sel_q;
  assign player_id    = player_q;
  assign winner       = winner_q;
  assign draw         = draw_q;
  assign move_count   = move_count_q;
  assign invalid_move = (state_q == VALIDATE) && bad_move;
  assign timeout      = turn_expired;
  assign state        = state_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// tb/tb_game_turn_controller.sv - randomized self-checking bench for game_turn_controller
module tb_game_turn_controller;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, confirm = 1'b0, check_done = 1'b0, winner_found = 1'b0;
  logic [2:0] col_in = 3'd0;
  logic       col_full;
  logic       board_rst_n, insert_en, check_req, invalid_move, timeout, draw;
  logic [2:0] col_sel, state;
  logic [1:0] player_id, winner;
  logic [5:0] move_count;

  int checks = 0;
  int errors = 0;

  int         board_h[7];
  logic       force_full = 1'b0;
  int         obs_ins, obs_inv, obs_lat, ins_cyc;
  logic [2:0] obs_ins_col, obs_clr_state;
  logic [1:0] obs_ins_player;
  logic       obs_done, obs_to, obs_clr_brst;

  game_turn_controller #(.TURN_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .confirm(confirm), .col_in(col_in),
    .col_full(col_full), .check_done(check_done), .winner_found(winner_found),
    .board_rst_n(board_rst_n), .insert_en(insert_en), .col_sel(col_sel),
    .player_id(player_id), .check_req(check_req), .invalid_move(invalid_move),
    .timeout(timeout), .winner(winner), .draw(draw), .move_count(move_count),
    .state(state)
  );

  always #5 clk = ~clk;

  // Board datapath stand-in: column heights filled by observed inserts.
  always_comb begin
    col_full = force_full;
    if (col_sel <= 3'd6 && board_h[col_sel] >= ROWS) col_full = 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_game;
    if (state != IDLE && state != GAME_OVER) begin
      rst = 1'b0; tick(); rst = 1'b1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    obs_clr_state = state;
    obs_clr_brst  = board_rst_n;
    for (int i = 0; i < 7; i++) board_h[i] = 0;
    tick();
  endtask

  // Drives one confirm and plays the win checker; records what the DUT did.
  task automatic play_move(input logic [2:0] col, input logic ff, input int delay, input logic win);
    int creq;
    obs_ins = 0; obs_inv = 0; obs_lat = -1; ins_cyc = -1; obs_done = 1'b0;
    obs_ins_col = 3'd0; obs_ins_player = 2'b00;
    confirm = 1'b1; col_in = col; force_full = ff;
    #1 obs_to = timeout;
    tick();
    confirm = 1'b0;
    creq = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0 && (state == WAIT_MOVE || state == GAME_OVER)) begin
        obs_done = 1'b1;
        obs_lat  = cyc - ins_cyc;
        break;
      end
      if (invalid_move) obs_inv++;
      if (insert_en) begin
        obs_ins++; obs_ins_col = col_sel; obs_ins_player = player_id; ins_cyc = cyc;
        if (col_sel <= 3'd6) board_h[col_sel]++;
      end
      check_done = 1'b0; winner_found = 1'b0;
      if (check_req) begin
        creq++;
        if (creq == delay + 1) begin check_done = 1'b1; winner_found = win; end
      end
      tick();
    end
    check_done = 1'b0; winner_found = 1'b0; force_full = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, IDLE); end
    checks++; if (board_rst_n !== 1'b1) begin errors++; $display("FAIL reset_board_rst_n got %0b exp 1", board_rst_n); end
    checks++; if (insert_en !== 1'b0) begin errors++; $display("FAIL reset_insert_en got %0b exp 0", insert_en); end
    checks++; if (check_req !== 1'b0) begin errors++; $display("FAIL reset_check_req got %0b exp 0", check_req); end
    checks++; if (col_sel !== 3'd0) begin errors++; $display("FAIL reset_col_sel got %0d exp 0", col_sel); end
    checks++; if (player_id !== 2'b01) begin errors++; $display("FAIL reset_player got %0b exp 01", player_id); end
    checks++; if (winner !== 2'b00 || draw !== 1'b0) begin errors++; $display("FAIL reset_result got w=%0b d=%0b exp w=00 d=0", winner, draw); end
    checks++; if (move_count !== 6'd0) begin errors++; $display("FAIL reset_move_count got %0d exp 0", move_count); end
    checks++; if (invalid_move !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses got inv=%0b to=%0b exp 0 0", invalid_move, timeout); end
    rst = 1'b1;
    tick();
    checks++; if (state !== IDLE) begin errors++; $display("FAIL post_reset_state got %0d exp %0d", state, IDLE); end
  endtask

  task automatic test_start;
    new_game();
    checks++; if (obs_clr_state !== CLEAR || obs_clr_brst !== 1'b0) begin errors++; $display("FAIL start_clear got st=%0d brst=%0b exp st=%0d brst=0", obs_clr_state, obs_clr_brst, CLEAR); end
    checks++; if (state !== WAIT_MOVE || board_rst_n !== 1'b1) begin errors++; $display("FAIL start_wait got st=%0d brst=%0b exp st=%0d brst=1", state, board_rst_n, WAIT_MOVE); end
    checks++; if (player_id !== 2'b01 || move_count !== 6'd0) begin errors++; $display("FAIL start_player got p=%0b mc=%0d exp p=01 mc=0", player_id, move_count); end
    start = 1'b1; tick(); start = 1'b0; tick();
    checks++; if (state !== WAIT_MOVE || board_rst_n !== 1'b1) begin errors++; $display("FAIL start_ignored got st=%0d brst=%0b exp st=%0d", state, board_rst_n, WAIT_MOVE); end
  endtask

  task automatic test_basic_move;
    play_move(3'd3, 1'b0, 2, 1'b0);
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b exp 1", obs_done); end
    checks++; if (obs_ins !== 1 || obs_ins_col !== 3'd3 || obs_ins_player !== 2'b01) begin errors++; $display("FAIL basic_insert got n=%0d col=%0d p=%0b exp n=1 col=3 p=01", obs_ins, obs_ins_col, obs_ins_player); end
    checks++; if (obs_lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", obs_lat); end
    checks++; if (player_id !== 2'b10 || move_count !== 6'd1) begin errors++; $display("FAIL basic_after got p=%0b mc=%0d exp p=10 mc=1", player_id, move_count); end
  endtask

  task automatic test_invalid;
    play_move(3'd5, 1'b1, 0, 1'b0);
    checks++; if (obs_inv !== 1 || obs_ins !== 0 || obs_done !== 1'b1) begin errors++; $display("FAIL invalid_full got inv=%0d ins=%0d done=%0b exp 1 0 1", obs_inv, obs_ins, obs_done); end
    checks++; if (player_id !== 2'b10 || move_count !== 6'd1) begin errors++; $display("FAIL invalid_full_player got p=%0b mc=%0d exp p=10 mc=1", player_id, move_count); end
    play_move(3'd7, 1'b0, 0, 1'b0);
    checks++; if (obs_inv !== 1 || obs_ins !== 0 || obs_done !== 1'b1) begin errors++; $display("FAIL invalid_col7 got inv=%0d ins=%0d done=%0b exp 1 0 1", obs_inv, obs_ins, obs_done); end
    checks++; if (player_id !== 2'b10 || state !== WAIT_MOVE) begin errors++; $display("FAIL invalid_col7_player got p=%0b st=%0d exp p=10 st=%0d", player_id, state, WAIT_MOVE); end
  endtask

  task automatic test_random_game;
    int exp_h[7];
    logic [1:0] exp_p, exp_w;
    logic exp_d, over, valid, ff, win;
    int exp_mc, delay;
    logic [2:0] col;
    for (int g = 0; g < 3; g++) begin
      new_game();
      for (int i = 0; i < 7; i++) exp_h[i] = 0;
      exp_p = 2'b01; exp_w = 2'b00; exp_d = 1'b0; exp_mc = 0; over = 1'b0;
      for (int m = 0; m < 60 && !over; m++) begin
        col   = 3'($urandom_range(0, 7));
        ff    = ($urandom_range(0, 7) == 0);
        delay = $urandom_range(0, 3);
        win   = (exp_mc >= 4) && ($urandom_range(0, 19) == 0);
        valid = (col <= 3'd6) && !ff;
        if (valid && exp_h[col] >= ROWS) valid = 1'b0;
        play_move(col, ff, delay, win);
        checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL rand_done g=%0d m=%0d got %0b exp 1", g, m, obs_done); end
        if (valid) begin
          checks++; if (obs_ins !== 1 || obs_inv !== 0 || obs_ins_col !== col || obs_ins_player !== exp_p) begin errors++; $display("FAIL rand_insert g=%0d m=%0d got n=%0d inv=%0d col=%0d p=%0b exp n=1 inv=0 col=%0d p=%0b", g, m, obs_ins, obs_inv, obs_ins_col, obs_ins_player, col, exp_p); end
          checks++; if (obs_lat !== delay + 2) begin errors++; $display("FAIL rand_latency g=%0d m=%0d got %0d exp %0d", g, m, obs_lat, delay + 2); end
          exp_h[col]++; exp_mc++;
          if (win) begin exp_w = exp_p; over = 1'b1; end
          else if (exp_mc == MAX_MOVES) begin exp_d = 1'b1; over = 1'b1; end
          else exp_p = (exp_p == 2'b01) ? 2'b10 : 2'b01;
        end else begin
          checks++; if (obs_inv !== 1 || obs_ins !== 0) begin errors++; $display("FAIL rand_reject g=%0d m=%0d got inv=%0d ins=%0d exp 1 0", g, m, obs_inv, obs_ins); end
        end
        checks++; if (player_id !== exp_p || move_count !== 6'(exp_mc)) begin errors++; $display("FAIL rand_state g=%0d m=%0d got p=%0b mc=%0d exp p=%0b mc=%0d", g, m, player_id, move_count, exp_p, exp_mc); end
      end
      checks++; if (winner !== exp_w || draw !== exp_d || state !== (over ? GAME_OVER : WAIT_MOVE)) begin errors++; $display("FAIL rand_end g=%0d got w=%0b d=%0b st=%0d exp w=%0b d=%0b over=%0b", g, winner, draw, state, exp_w, exp_d, over); end
    end
  endtask

  task automatic test_win;
    int ins_seen;
    new_game();
    play_move(3'd4, 1'b0, 1, 1'b1);
    checks++; if (obs_ins !== 1 || winner !== 2'b01 || state !== GAME_OVER || move_count !== 6'd1) begin errors++; $display("FAIL win_p1 got ins=%0d w=%0b st=%0d mc=%0d exp 1 01 %0d 1", obs_ins, winner, state, move_count, GAME_OVER); end
    ins_seen = 0;
    confirm = 1'b1; col_in = 3'd2; tick(); confirm = 1'b0;
    for (int i = 0; i < 4; i++) begin if (insert_en) ins_seen++; tick(); end
    checks++; if (state !== GAME_OVER || ins_seen !== 0 || move_count !== 6'd1 || winner !== 2'b01) begin errors++; $display("FAIL win_hold got st=%0d ins=%0d mc=%0d w=%0b exp %0d 0 1 01", state, ins_seen, move_count, winner, GAME_OVER); end
    new_game();
    checks++; if (state !== WAIT_MOVE || winner !== 2'b00 || move_count !== 6'd0 || player_id !== 2'b01) begin errors++; $display("FAIL win_restart got st=%0d w=%0b mc=%0d p=%0b exp %0d 00 0 01", state, winner, move_count, player_id, WAIT_MOVE); end
  endtask

  task automatic test_draw;
    new_game();
    for (int i = 0; i < MAX_MOVES; i++) begin
      play_move(3'(i % COLS), 1'b0, $urandom_range(0, 2), 1'b0);
      if (i == MAX_MOVES - 2) begin
        checks++; if (state !== WAIT_MOVE || draw !== 1'b0) begin errors++; $display("FAIL draw_early got st=%0d d=%0b exp %0d 0", state, draw, WAIT_MOVE); end
      end
    end
    checks++; if (draw !== 1'b1 || winner !== 2'b00 || state !== GAME_OVER || move_count !== 6'd42) begin errors++; $display("FAIL draw_end got d=%0b w=%0b st=%0d mc=%0d exp 1 00 %0d 42", draw, winner, state, move_count, GAME_OVER); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (draw !== 1'b1 || move_count !== 6'd42) begin errors++; $display("FAIL draw_hold got d=%0b mc=%0d exp 1 42", draw, move_count); end
  endtask

  task automatic test_abort;
    int ins_seen;
    new_game();
    confirm = 1'b1; col_in = 3'd0; tick(); confirm = 1'b0;
    tick(); tick();
    checks++; if (check_req !== 1'b1 || state !== CHECK) begin errors++; $display("FAIL abort_setup got req=%0b st=%0d exp 1 %0d", check_req, state, CHECK); end
    rst = 1'b0;
    #1;
    checks++; if (state !== IDLE || check_req !== 1'b0 || insert_en !== 1'b0) begin errors++; $display("FAIL abort_async got st=%0d req=%0b ins=%0b exp %0d 0 0", state, check_req, insert_en, IDLE); end
    tick(); tick();
    rst = 1'b1;
    ins_seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (insert_en) ins_seen++; end
    checks++; if (ins_seen !== 0 || state !== IDLE) begin errors++; $display("FAIL abort_after got ins=%0d st=%0d exp 0 %0d", ins_seen, state, IDLE); end
  endtask

  task automatic test_timer;
    new_game();
`ifdef TURN_TIMER_EN
    for (int k = 1; k <= 10; k++) begin
      checks++; if (timeout !== (k == 10)) begin errors++; $display("FAIL timer_pulse cycle=%0d got %0b exp %0b", k, timeout, (k == 10)); end
      if (k < 10) tick();
    end
    tick();
    checks++; if (player_id !== 2'b10 || state !== WAIT_MOVE || move_count !== 6'd0 || timeout !== 1'b0) begin errors++; $display("FAIL timer_toggle got p=%0b st=%0d mc=%0d to=%0b exp 10 %0d 0 0", player_id, state, move_count, timeout); end
    for (int k = 2; k <= 10; k++) tick();
    play_move(3'd2, 1'b0, 0, 1'b0);
    checks++; if (obs_to !== 1'b0 || obs_ins !== 1 || obs_ins_player !== 2'b10) begin errors++; $display("FAIL timer_confirm_wins got to=%0b ins=%0d p=%0b exp 0 1 10", obs_to, obs_ins, obs_ins_player); end
    checks++; if (player_id !== 2'b01 || move_count !== 6'd1) begin errors++; $display("FAIL timer_after_move got p=%0b mc=%0d exp 01 1", player_id, move_count); end
`else
    begin
      int to_seen;
      to_seen = 0;
      for (int i = 0; i < 30; i++) begin if (timeout) to_seen++; tick(); end
      checks++; if (to_seen !== 0 || player_id !== 2'b01 || state !== WAIT_MOVE) begin errors++; $display("FAIL no_timer got to=%0d p=%0b st=%0d exp 0 01 %0d", to_seen, player_id, state, WAIT_MOVE); end
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 7; i++) board_h[i] = 0;
    test_reset();
    test_start();
    test_basic_move();
    test_invalid();
    test_random_game();
    test_win();
    test_draw();
    test_abort();
    test_timer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got time limit exp bench completion");
    $fatal(1, "bench did not complete");
  end

endmodule
